dispatch_rst_ctrl: RTL and testbench

//  Dispatch-side producer for the issue stage. Holds the register result status

---
 rtl/dispatch_rst_ctrl_pkg.sv | 44 ++++
 rtl/dispatch_rst_ctrl_rst_table.sv | 68 ++++++
 rtl/dispatch_rst_ctrl.sv | 115 +++++++++++
 tb/tb_dispatch_rst_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_rst_ctrl_pkg.sv
// Shared types for the dispatch / register-status-table block.
// FU indices, RST entry layout, dispatch FSM states and tag helpers.
package dispatch_rst_ctrl_pkg;

    localparam int NREGS = 32;
    localparam int NFU   = 5;
    localparam int TAGW  = 3;
    localparam int RW    = 5;
    localparam int FUW   = 3;

    typedef enum logic [FUW-1:0] {
        FU_ALU    = 3'd0,
        FU_LDST   = 3'd1,
        FU_BRANCH = 3'd2,
        FU_MATRIX = 3'd3,
        FU_GEMM   = 3'd4
    } fu_idx_e;

    typedef struct packed {
        logic           busy;
        logic [FUW-1:0] fu;
        logic           spec;
    } rst_entry_t;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_SPEC,
        ST_FLUSH,
        ST_HALTED
    } disp_state_e;

    localparam logic [TAGW-1:0] TAG_READY = '0;

    function automatic logic [NFU-1:0] fu_onehot(input logic [FUW-1:0] fu);
        return NFU'(1) << fu;
    endfunction

    // Tag k+1 names the producing FU; a same-cycle writeback makes it ready.
    function automatic logic [TAGW-1:0] rst_tag(input rst_entry_t e,
                                                input logic bypass);
        return (e.busy && !bypass) ? TAGW'(e.fu) + TAGW'(1) : TAG_READY;
    endfunction

endpackage

// File: rtl/dispatch_rst_ctrl_rst_table.sv
// Register result status table: two tag read ports with writeback
// bypass, one dispatch set port, writeback clear and spec squash/commit.
module dispatch_rst_ctrl_rst_table
    import dispatch_rst_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [RW-1:0]   i_rs1,
    input  logic [RW-1:0]   i_rs2,
    input  logic [RW-1:0]   i_chk_rd,
    input  logic            i_set_en,
    input  logic [RW-1:0]   i_set_rd,
    input  logic [FUW-1:0]  i_set_fu,
    input  logic            i_set_spec,
    input  logic            i_wb_valid,
    input  logic [FUW-1:0]  i_wb_fu,
    input  logic [RW-1:0]   i_wb_rd,
    input  logic            i_squash,
    input  logic            i_commit,
    output logic [TAGW-1:0] o_t1,
    output logic [TAGW-1:0] o_t2,
    output logic            o_rd_busy,
    output logic            o_any_busy
);

    rst_entry_t r_tab [NREGS];
    rst_entry_t w_nxt [NREGS];
    rst_entry_t w_e1;
    rst_entry_t w_e2;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_nxt[i] = r_tab[i];
            if (i_wb_valid && i_wb_rd == RW'(i) && r_tab[i].fu == i_wb_fu)
                w_nxt[i] = '0;
            if (i_squash && w_nxt[i].spec)
                w_nxt[i] = '0;
            if (i_commit)
                w_nxt[i].spec = 1'b0;
            // Dispatch set overrides the clears on the same register.
            if (i_set_en && i != 0 && i_set_rd == RW'(i))
                w_nxt[i] = '{busy: 1'b1, fu: i_set_fu, spec: i_set_spec};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++)
                r_tab[i] <= '0;
        end else begin
            r_tab <= w_nxt;
        end
    end

    always_comb begin
        w_e1 = r_tab[i_rs1];
        w_e2 = r_tab[i_rs2];
        o_t1 = rst_tag(w_e1, i_wb_valid && i_wb_rd == i_rs1
                             && i_wb_fu == w_e1.fu);
        o_t2 = rst_tag(w_e2, i_wb_valid && i_wb_rd == i_rs2
                             && i_wb_fu == w_e2.fu);
        o_rd_busy = r_tab[i_chk_rd].busy;
        o_any_busy = 1'b0;
        for (int i = 0; i < NREGS; i++)
            o_any_busy = o_any_busy | r_tab[i].busy;
    end

endmodule

// File: rtl/dispatch_rst_ctrl.sv
// Dispatch producer: hazard/occupancy stall, FUST row enables, operand
// tags, one-branch speculation window with squash, and HALT quiesce.
module dispatch_rst_ctrl
    import dispatch_rst_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    input  logic [FUW-1:0]  i_in_fu,
    input  logic [RW-1:0]   i_in_rd,
    input  logic [RW-1:0]   i_in_rs1,
    input  logic [RW-1:0]   i_in_rs2,
    input  logic            i_in_wen,
    input  logic            i_in_halt,
    output logic            o_in_ready,
    input  logic [NFU-1:0]  i_fust_busy,
    input  logic            i_wb_valid,
    input  logic [FUW-1:0]  i_wb_fu,
    input  logic [RW-1:0]   i_wb_rd,
    input  logic            i_branch_resolved,
    input  logic            i_branch_miss,
    input  logic            i_freeze,
    output logic [NFU-1:0]  o_fust_en,
    output logic [FUW-1:0]  o_fu_t,
    output logic [TAGW-1:0] o_t1,
    output logic [TAGW-1:0] o_t2,
    output logic            o_halt
);

    disp_state_e     r_state;
    logic            r_halt;
    logic [TAGW-1:0] w_t1;
    logic [TAGW-1:0] w_t2;
    logic            w_rd_busy;
    logic            w_any_busy;
    logic            w_stall;
    logic            w_acc;
    logic            w_resolve;
    logic            w_squash;
    logic            w_commit;
    logic            w_set_en;
    logic            w_set_spec;

    always_comb begin
        w_stall = i_freeze
                | (|(i_fust_busy & fu_onehot(i_in_fu)))
                | (i_in_wen & w_rd_busy)
                | (r_state == ST_FLUSH)
                | (r_state == ST_HALTED)
                | (r_state == ST_SPEC && i_in_fu == FU_BRANCH);
        o_in_ready = !i_rst && !w_stall;
        w_acc = i_in_valid && o_in_ready;
        w_resolve = (r_state == ST_SPEC) && i_branch_resolved;
        w_squash = w_resolve && i_branch_miss;
        w_commit = w_resolve && !i_branch_miss;
        // A dispatch racing its own branch's mispredict is wrong-path.
        w_set_en = w_acc && i_in_wen && (i_in_rd != '0) && !w_squash;
        w_set_spec = (r_state == ST_SPEC) && !w_resolve;
        o_fust_en = w_acc ? fu_onehot(i_in_fu) : '0;
        o_fu_t = w_acc ? i_in_fu : '0;
        o_t1 = w_acc ? w_t1 : TAG_READY;
        o_t2 = w_acc ? w_t2 : TAG_READY;
        o_halt = r_halt;
    end

    dispatch_rst_ctrl_rst_table u_rst (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rs1      (i_in_rs1),
        .i_rs2      (i_in_rs2),
        .i_chk_rd   (i_in_rd),
        .i_set_en   (w_set_en),
        .i_set_rd   (i_in_rd),
        .i_set_fu   (i_in_fu),
        .i_set_spec (w_set_spec),
        .i_wb_valid (i_wb_valid),
        .i_wb_fu    (i_wb_fu),
        .i_wb_rd    (i_wb_rd),
        .i_squash   (w_squash),
        .i_commit   (w_commit),
        .o_t1       (w_t1),
        .o_t2       (w_t2),
        .o_rd_busy  (w_rd_busy),
        .o_any_busy (w_any_busy)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_NORMAL;
            r_halt <= 1'b0;
        end else begin
            r_halt <= (r_state == ST_HALTED) && !w_any_busy
                      && (i_fust_busy == '0);
            case (r_state)
                ST_NORMAL: begin
                    if (w_acc && i_in_halt)
                        r_state <= ST_HALTED;
                    else if (w_acc && i_in_fu == FU_BRANCH)
                        r_state <= ST_SPEC;
                end
                ST_SPEC: begin
                    if (w_acc && i_in_halt)
                        r_state <= ST_HALTED;
                    else if (w_squash)
                        r_state <= ST_FLUSH;
                    else if (w_commit)
                        r_state <= ST_NORMAL;
                end
                ST_FLUSH: r_state <= ST_NORMAL;
                default:  r_state <= r_state;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_rst_ctrl.sv
// Bench for dispatch_rst_ctrl: directed vector table, reset checks and
// a randomized run against a register-array reference model.
module tb_dispatch_rst_ctrl;
    import dispatch_rst_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_wen, in_halt, in_ready;
    logic [2:0] in_fu, wb_fu, fu_t, t1, t2;
    logic [4:0] in_rd, in_rs1, in_rs2, wb_rd, fust_busy, fust_en;
    logic       wb_valid, br_res, br_miss, freeze, halt;

    always #5 clk = ~clk;

    dispatch_rst_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .i_in_fu(in_fu), .i_in_rd(in_rd),
        .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_wen(in_wen),
        .i_in_halt(in_halt), .o_in_ready(in_ready),
        .i_fust_busy(fust_busy), .i_wb_valid(wb_valid), .i_wb_fu(wb_fu),
        .i_wb_rd(wb_rd), .i_branch_resolved(br_res),
        .i_branch_miss(br_miss), .i_freeze(freeze),
        .o_fust_en(fust_en), .o_fu_t(fu_t), .o_t1(t1), .o_t2(t2),
        .o_halt(halt)
    );

    typedef struct {
        bit v; bit [2:0] fu; bit [4:0] rd, rs1, rs2; bit wen, hlt;
        bit [4:0] fb; bit wbv; bit [2:0] wbfu; bit [4:0] wbrd;
        bit br, miss, frz;
    } in_t;

    typedef struct {
        in_t in; bit rdy; bit [4:0] en; bit [2:0] t1, t2; bit hlt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic in_t mk(bit v, bit [2:0] fu, bit [4:0] rd,
        bit [4:0] rs1, bit [4:0] rs2, bit wen, bit hlt, bit [4:0] fb,
        bit wbv, bit [2:0] wbfu, bit [4:0] wbrd, bit br, bit miss, bit frz);
        in_t x;
        x.v = v; x.fu = fu; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        x.wen = wen; x.hlt = hlt; x.fb = fb; x.wbv = wbv; x.wbfu = wbfu;
        x.wbrd = wbrd; x.br = br; x.miss = miss; x.frz = frz;
        return x;
    endfunction

    task automatic add(in_t x, bit rdy, bit [4:0] en, bit [2:0] a,
                       bit [2:0] b, bit h);
        vec_t e;
        e.in = x; e.rdy = rdy; e.en = en; e.t1 = a; e.t2 = b; e.hlt = h;
        tbl.push_back(e);
    endtask

    task automatic drive(in_t x);
        in_valid = x.v; in_fu = x.fu; in_rd = x.rd; in_rs1 = x.rs1;
        in_rs2 = x.rs2; in_wen = x.wen; in_halt = x.hlt; fust_busy = x.fb;
        wb_valid = x.wbv; wb_fu = x.wbfu; wb_rd = x.wbrd;
        br_res = x.br; br_miss = x.miss; freeze = x.frz;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: one status record per architectural register.
    bit       m_busy [32];
    bit [2:0] m_fu   [32];
    bit       m_spec [32];
    int       m_mode;  // 0 normal, 1 branch pending, 2 flush, 3 halted
    bit       m_halt;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_busy[r] = 0; m_fu[r] = 0; m_spec[r] = 0;
        end
        m_mode = 0; m_halt = 0;
    endfunction

    function automatic bit m_ready(in_t x);
        if (x.frz || x.fb[x.fu]) return 0;
        if (x.wen && m_busy[x.rd]) return 0;
        if (m_mode == 2 || m_mode == 3) return 0;
        if (m_mode == 1 && x.fu == 2) return 0;
        return 1;
    endfunction

    function automatic bit [2:0] m_tag(bit [4:0] rs, in_t x);
        if (!(x.v && m_ready(x))) return 0;
        if (rs == 0 || !m_busy[rs]) return 0;
        if (x.wbv && x.wbrd == rs && x.wbfu == m_fu[rs]) return 0;
        return m_fu[rs] + 3'd1;
    endfunction

    function automatic void model_step(in_t x);
        bit acc, res, sq, idle;
        acc = x.v && m_ready(x);
        res = (m_mode == 1) && x.br;
        sq = res && x.miss;
        idle = 1;
        for (int r = 0; r < 32; r++) if (m_busy[r]) idle = 0;
        m_halt = (m_mode == 3) && idle && (x.fb == 0);
        if (x.wbv && m_busy[x.wbrd] && m_fu[x.wbrd] == x.wbfu) begin
            m_busy[x.wbrd] = 0; m_spec[x.wbrd] = 0;
        end
        for (int r = 0; r < 32; r++) begin
            if (sq && m_spec[r]) m_busy[r] = 0;
            if (res) m_spec[r] = 0;
        end
        if (acc && x.wen && x.rd != 0 && !sq) begin
            m_busy[x.rd] = 1; m_fu[x.rd] = x.fu;
            m_spec[x.rd] = (m_mode == 1) && !res;
        end
        if (acc && x.hlt && m_mode < 2) m_mode = 3;
        else if (m_mode == 0 && acc && x.fu == 2) m_mode = 1;
        else if (res) m_mode = x.miss ? 2 : 0;
        else if (m_mode == 2) m_mode = 0;
    endfunction

    task automatic do_reset();
        in_t z;
        z = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        drive(z);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_en", fust_en, 0);
        chk("rst_halt", halt, 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        in_t x;
        bit e_rdy;
        int hcnt;
        // Directed vectors: one row per cycle.
        add(mk(1,0,3,1,2,1,0,0,0,0,0,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(1,0,6,3,0,1,0,0,0,0,0,0,0,0), 1, 5'b00001, 1, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,1,0,3,0,0,0), 1, 0, 0, 0, 0);
        add(mk(1,0,0,3,6,0,0,0,1,0,6,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(1,1,5,0,0,1,0,5'b00010,0,0,0,0,0,0), 0, 0, 0, 0, 0);
        add(mk(1,1,5,0,0,1,0,0,0,0,0,0,0,0), 1, 5'b00010, 0, 0, 0);
        add(mk(1,0,5,0,0,1,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0);
        add(mk(1,0,5,0,0,1,0,0,1,1,5,0,0,0), 0, 0, 0, 0, 0);
        add(mk(1,0,5,0,0,1,0,0,0,0,0,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(1,0,4,5,0,1,0,0,0,0,0,0,0,0), 1, 5'b00001, 1, 0, 0);
        add(mk(1,0,0,4,5,0,0,0,1,0,4,0,0,0), 1, 5'b00001, 0, 1, 0);
        add(mk(1,0,4,0,0,1,0,0,0,0,0,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,1,2,4,0,0,0), 1, 0, 0, 0, 0);
        add(mk(1,0,0,4,0,0,0,0,0,0,0,0,0,0), 1, 5'b00001, 1, 0, 0);
        add(mk(1,2,0,4,5,0,0,0,0,0,0,0,0,0), 1, 5'b00100, 1, 1, 0);
        add(mk(1,0,7,0,0,1,0,0,0,0,0,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(1,2,0,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,0,0,0,1,1,0), 1, 0, 0, 0, 0);
        add(mk(1,0,0,7,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0);
        add(mk(1,0,0,7,4,0,0,0,0,0,0,0,0,0), 1, 5'b00001, 0, 1, 0);
        add(mk(1,0,0,0,0,0,0,0,1,0,4,0,0,1), 0, 0, 0, 0, 0);
        add(mk(1,0,0,4,0,0,0,0,0,0,0,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(1,2,0,0,0,0,0,0,0,0,0,0,0,0), 1, 5'b00100, 0, 0, 0);
        add(mk(1,0,9,0,0,1,0,0,0,0,0,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0), 1, 0, 0, 0, 0);
        add(mk(1,0,0,9,0,0,0,0,0,0,0,0,0,0), 1, 5'b00001, 1, 0, 0);
        add(mk(1,2,0,0,0,0,0,0,0,0,0,0,0,0), 1, 5'b00100, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,1,0,5,1,0,0), 1, 0, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,1,0,9,0,0,0), 1, 0, 0, 0, 0);
        add(mk(1,3,10,0,0,1,0,0,0,0,0,0,0,0), 1, 5'b01000, 0, 0, 0);
        add(mk(1,0,0,0,0,0,1,5'b01000,0,0,0,0,0,0), 1, 5'b00001, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,5'b01000,0,0,0,0,0,0), 0, 0, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,1,3,10,0,0,0), 0, 0, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0);
        add(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 1);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            #2;
            chk($sformatf("v%0d_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("v%0d_en", i), fust_en, tbl[i].en);
            chk($sformatf("v%0d_t1", i), t1, tbl[i].t1);
            chk($sformatf("v%0d_t2", i), t2, tbl[i].t2);
            chk($sformatf("v%0d_halt", i), halt, tbl[i].hlt);
            @(posedge clk); #1;
        end

        // Reset while halted with an instruction presented.
        drive(mk(1,0,3,0,0,1,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        #2;
        chk("midrst_ready", in_ready, 0);
        chk("midrst_en", fust_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        #2;
        chk("postrst_halt", halt, 0);
        chk("postrst_ready", in_ready, 1);
        chk("postrst_en", fust_en, 5'b00001);

        // Randomized run against the reference model.
        do_reset();
        hcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            x.v = ($urandom % 5) != 0;
            x.fu = 3'($urandom_range(0, 4));
            x.rd = 5'($urandom_range(0, 7));
            x.rs1 = 5'($urandom_range(0, 7));
            x.rs2 = 5'($urandom_range(0, 7));
            x.wen = ($urandom % 10) < 7;
            x.hlt = ($urandom % 150) == 0;
            x.fb = (($urandom % 4) == 0) ? 5'($urandom) : 5'd0;
            x.wbv = ($urandom % 10) < 6;
            x.wbrd = 5'($urandom_range(0, 7));
            x.wbfu = (m_busy[x.wbrd] && ($urandom % 10) < 7)
                     ? m_fu[x.wbrd] : 3'($urandom_range(0, 4));
            x.br = ($urandom % 5) == 0;
            x.miss = $urandom % 2;
            x.frz = ($urandom % 10) == 0;
            hcnt = (m_mode == 3) ? hcnt + 1 : 0;
            drive(x);
            if (hcnt > 25 || ($urandom % 500) == 0) begin
                rst = 1'b1;
                #2;
                chk("r_rst_ready", in_ready, 0);
                chk("r_rst_en", fust_en, 0);
                chk("r_rst_halt", halt, m_halt);
                model_reset();
                hcnt = 0;
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                #2;
                e_rdy = m_ready(x);
                chk("r_ready", in_ready, e_rdy);
                chk("r_en", fust_en,
                    (x.v && e_rdy) ? (5'd1 << x.fu) : 5'd0);
                chk("r_fu_t", fu_t, (x.v && e_rdy) ? x.fu : 3'd0);
                chk("r_t1", t1, m_tag(x.rs1, x));
                chk("r_t2", t2, m_tag(x.rs2, x));
                chk("r_halt", halt, m_halt);
                model_step(x);
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
